ghost_mode_scheduler: RTL



---
 rtl/ghost_mode_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode scheduler: 60 Hz frame tick, scatter/chase timeline, fright timer,
// per-ghost EATEN tracking and house release. Mode encoding: 0 SCATTER, 1 CHASE, 2 AFFRAID, 3 EATEN.
module ghost_mode_scheduler #(
  parameter int unsigned       CLOCK_FREQ          = 25_000_000,
  parameter int unsigned       TICK_DIV            = CLOCK_FREQ / 60,
  parameter int unsigned       SCATTER_FRAMES      = 420,
  parameter int unsigned       SCATTER_LAST_FRAMES = 300,
  parameter int unsigned       CHASE_FRAMES        = 1200,
  parameter int unsigned       FRIGHT_FRAMES       = 360,
  parameter logic [0:3][15:0]  RELEASE_FRAMES      = {16'd0, 16'd60, 16'd180, 16'd300}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pause,
  input  logic            restart_ghosts,
  input  logic            power_pellet,
  input  logic [3:0]      ghost_eaten,
  input  logic [3:0]      in_housse,
  output logic [3:0][1:0] ghost_state,
  output logic [3:0]      leave_housse,
  output logic            frightened_active,
  output logic [1:0]      eaten_count,
  output logic [2:0]      global_phase
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {SCATTER, CHASE, AFFRAID, EATEN} ghost_modes_t;
  typedef enum logic [2:0] {
    SCAT0, CHASE0, SCAT1, CHASE1, SCAT2, CHASE2, SCAT3, CHASE_FOREVER
  } phase_e;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]  fright_cnt_q, fright_cnt_d;
  logic              fright_active_q, fright_active_d;
  logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [3:0]        leave_q, leave_d;
  logic [1:0]        eaten_cnt_q, eaten_cnt_d;
  ghost_modes_t [3:0] ghost_state_q, ghost_state_d;

  logic              tick;
  logic              fright_expire;
  logic [CNT_W-1:0]  phase_last;
  ghost_modes_t      gmode;
  logic [3:0]        valid_eat;
  logic [2:0]        n_eat;
  logic [2:0]        eat_sum;

  // State registers; pause freezes everything including the tick divider.
  always_ff @(posedge clk) begin
    if (!reset || restart_ghosts) begin
      tick_cnt_q      <= '0;
      phase_q         <= SCAT0;
      phase_cnt_q     <= '0;
      fright_cnt_q    <= '0;
      fright_active_q <= 1'b0;
      rel_cnt_q       <= '0;
      leave_q         <= '0;
      eaten_cnt_q     <= '0;
      ghost_state_q   <= {4{SCATTER}};
    end else if (!pause) begin
      tick_cnt_q      <= tick_cnt_d;
      phase_q         <= phase_d;
      phase_cnt_q     <= phase_cnt_d;
      fright_cnt_q    <= fright_cnt_d;
      fright_active_q <= fright_active_d;
      rel_cnt_q       <= rel_cnt_d;
      leave_q         <= leave_d;
      eaten_cnt_q     <= eaten_cnt_d;
      ghost_state_q   <= ghost_state_d;
    end
  end

  always_comb begin
    tick_cnt_d      = tick_cnt_q;
    phase_d         = phase_q;
    phase_cnt_d     = phase_cnt_q;
    fright_cnt_d    = fright_cnt_q;
    fright_active_d = fright_active_q;
    rel_cnt_d       = rel_cnt_q;
    leave_d         = leave_q;
    eaten_cnt_d     = eaten_cnt_q;
    ghost_state_d   = ghost_state_q;
    valid_eat       = '0;
    n_eat           = '0;
    eat_sum         = '0;

    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Fright timer; a pellet always reloads, even on a tick.
    fright_expire = fright_active_q && tick && !power_pellet && (fright_cnt_q == CNT_W'(1));
    if (power_pellet) begin
      fright_cnt_d    = CNT_W'(FRIGHT_FRAMES);
      fright_active_d = 1'b1;
    end else if (fright_active_q && tick) begin
      fright_cnt_d = fright_cnt_q - CNT_W'(1);
      if (fright_cnt_q == CNT_W'(1)) fright_active_d = 1'b0;
    end

    // Timeline is frozen from the pellet cycle through the whole fright.
    if (phase_q == SCAT3)      phase_last = CNT_W'(SCATTER_LAST_FRAMES - 1);
    else if (phase_q[0])       phase_last = CNT_W'(CHASE_FRAMES - 1);
    else                       phase_last = CNT_W'(SCATTER_FRAMES - 1);

    if (tick && !fright_active_q && !power_pellet && (phase_q != CHASE_FOREVER)) begin
      if (phase_cnt_q == phase_last) begin
        phase_d     = phase_e'(phase_q + 3'd1);
        phase_cnt_d = '0;
      end else begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
      end
    end

    gmode = phase_d[0] ? CHASE : SCATTER;

    for (int i = 0; i < 4; i++) begin
      valid_eat[i] = (ghost_state_q[i] == AFFRAID) && ghost_eaten[i];
      n_eat        = n_eat + 3'(valid_eat[i]);
      if ((ghost_state_q[i] == EATEN) && in_housse[i])
        ghost_state_d[i] = gmode;
      else if (valid_eat[i])
        ghost_state_d[i] = EATEN;
      else if (power_pellet && (ghost_state_q[i] != EATEN))
        ghost_state_d[i] = AFFRAID;
      else if (fright_expire && (ghost_state_q[i] == AFFRAID))
        ghost_state_d[i] = gmode;
      else if ((ghost_state_q[i] == SCATTER) || (ghost_state_q[i] == CHASE))
        ghost_state_d[i] = gmode;
    end

    // Score index restarts with each pellet, counting a same-cycle eat.
    eat_sum     = power_pellet ? n_eat : 3'(eaten_cnt_q) + n_eat;
    eaten_cnt_d = (eat_sum > 3'd3) ? 2'd3 : eat_sum[1:0];

    if (tick && (rel_cnt_q != 16'hFFFF)) rel_cnt_d = rel_cnt_q + CNT_W'(1);
    for (int i = 0; i < 4; i++) begin
      leave_d[i] = leave_q[i] | (rel_cnt_d >= RELEASE_FRAMES[i]);
    end
  end

  assign ghost_state       = ghost_state_q;
  assign leave_housse      = leave_q;
  assign frightened_active = fright_active_q;
  assign eaten_count       = eaten_cnt_q;
  assign global_phase      = phase_q;

endmodule
